// File: rtl/spi_pkg.sv
// Shared types and default timing for the SPI initiator slice.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_state_t;

    localparam int SPI_WIDTH    = 16;
    localparam int SPI_CLK_DIV  = 4;
    localparam int SPI_CS_SETUP = 4;
    localparam int SPI_CS_HOLD  = 2;
    localparam int SPI_CS_IDLE  = 4;

    // Largest of three phase lengths; sizes the shared phase counter.
    function automatic int spi_max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/spi_master_unit_if.sv
// Host-side handshake plus SPI pin bundle for spi_master_unit.
// master modport = the initiator itself; slave modport = host/pin side.
interface spi_master_unit_if import spi_pkg::*; #(
    parameter int WIDTH = SPI_WIDTH
) ();
    logic             start;
    logic [WIDTH-1:0] data_to_mosi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] data_from_miso;
    logic             CLK;
    logic             CS;
    logic             MOSI;
    logic             MISO;

    modport master (
        input  start, data_to_mosi, MISO,
        output busy, done, data_from_miso, CLK, CS, MOSI
    );

    modport slave (
        output start, data_to_mosi, MISO,
        input  busy, done, data_from_miso, CLK, CS, MOSI
    );
endinterface

// File: rtl/spi_clk_gen.sv
// SPI clock divider: while enabled, toggles the CLK level every CLK_DIV
// SYS_CLK cycles and flags the edge about to happen with a one-cycle tick.
// Disabled, it parks CLK low with the divider cleared.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic SYS_CLK,
    input  logic all_clear,
    input  logic i_en,
    output logic o_clk,
    output logic o_rise_tick,
    output logic o_fall_tick
);
    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] r_div;
    logic             r_clk;
    logic             w_wrap;

    // Decode the end of a half-period and which edge it produces.
    always_comb begin
        w_wrap      = i_en && (r_div == DIV_W'(CLK_DIV - 1));
        o_rise_tick = w_wrap && !r_clk;
        o_fall_tick = w_wrap && r_clk;
    end

    // Divider counter and CLK level register.
    always_ff @(posedge SYS_CLK) begin
        if (all_clear) begin
            r_div <= '0;
            r_clk <= 1'b0;
        end else if (!i_en) begin
            r_div <= '0;
            r_clk <= 1'b0;
        end else if (w_wrap) begin
            r_div <= '0;
            r_clk <= ~r_clk;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    assign o_clk = r_clk;

endmodule

// File: rtl/spi_master_unit.sv
// SPI initiator: one MSB-first frame per accepted start, CLK idles low,
// MOSI changes on CLK fall, MISO sampled on CLK rise.
// Optional feature macro: SPI_MASTER_LOOPBACK_EN adds a 'loopback' input
// that feeds the internal MOSI into the receive shifter instead of MISO.
module spi_master_unit import spi_pkg::*; #(
    parameter int WIDTH    = SPI_WIDTH,
    parameter int CLK_DIV  = SPI_CLK_DIV,
    parameter int CS_SETUP = SPI_CS_SETUP,
    parameter int CS_HOLD  = SPI_CS_HOLD,
    parameter int CS_IDLE  = SPI_CS_IDLE
) (
    input  logic SYS_CLK,
    input  logic all_clear,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic loopback,
`endif
    spi_master_unit_if.master bus
);
    localparam int PH_W  = $clog2(spi_max3(CS_SETUP, CS_HOLD, CS_IDLE) + 1);
    localparam int BIT_W = $clog2(WIDTH);

    spi_state_t       r_state;
    spi_state_t       w_next_state;
    logic [PH_W-1:0]  r_phase;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0] r_tx_sr;
    logic [WIDTH-1:0] r_rx_sr;
    logic [WIDTH-1:0] r_rx_out;
    logic             r_cs;
    logic             r_mosi;
    logic             r_busy;
    logic             r_done;
    logic             w_clk_en;
    logic             w_clk;
    logic             w_rise_tick;
    logic             w_fall_tick;
    logic             w_sample;

    assign w_clk_en = (r_state == XFER);

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .SYS_CLK     (SYS_CLK),
        .all_clear   (all_clear),
        .i_en        (w_clk_en),
        .o_clk       (w_clk),
        .o_rise_tick (w_rise_tick),
        .o_fall_tick (w_fall_tick)
    );

    // Select the bit that enters the receive shifter on each CLK rise.
    always_comb begin
`ifdef SPI_MASTER_LOOPBACK_EN
        if (loopback) begin
            w_sample = r_mosi;
        end else begin
            w_sample = bus.MISO;
        end
`else
        w_sample = bus.MISO;
`endif
    end

    // Next-state logic: timed phases end on the phase counter, XFER on the last fall.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) w_next_state = SETUP;
                else           w_next_state = IDLE;
            end
            SETUP: begin
                if (r_phase == PH_W'(CS_SETUP - 1)) w_next_state = XFER;
                else                                w_next_state = SETUP;
            end
            XFER: begin
                if (w_fall_tick && (r_bit_cnt == BIT_W'(WIDTH - 1))) w_next_state = HOLD;
                else                                                 w_next_state = XFER;
            end
            HOLD: begin
                if (r_phase == PH_W'(CS_HOLD - 1)) w_next_state = GAP;
                else                               w_next_state = HOLD;
            end
            GAP: begin
                if (r_phase == PH_W'(CS_IDLE - 1)) w_next_state = IDLE;
                else                               w_next_state = GAP;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge SYS_CLK) begin
        if (all_clear) r_state <= IDLE;
        else           r_state <= w_next_state;
    end

    // Phase counter for SETUP/HOLD/GAP; restarts on every state change.
    always_ff @(posedge SYS_CLK) begin
        if (all_clear || (w_next_state != r_state)) begin
            r_phase <= '0;
        end else if ((r_state == SETUP) || (r_state == HOLD) || (r_state == GAP)) begin
            r_phase <= r_phase + PH_W'(1);
        end else begin
            r_phase <= '0;
        end
    end

    // Datapath: shift registers, bit counter and registered pin/handshake outputs.
    always_ff @(posedge SYS_CLK) begin
        if (all_clear) begin
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_rx_out  <= '0;
            r_bit_cnt <= '0;
            r_cs      <= 1'b1;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_tx_sr   <= bus.data_to_mosi;
                        r_rx_sr   <= '0;
                        r_bit_cnt <= '0;
                        r_cs      <= 1'b0;
                        r_mosi    <= bus.data_to_mosi[WIDTH-1];
                        r_busy    <= 1'b1;
                    end
                end
                XFER: begin
                    if (w_rise_tick) begin
                        r_rx_sr <= {r_rx_sr[WIDTH-2:0], w_sample};
                    end
                    if (w_fall_tick) begin
                        r_tx_sr <= r_tx_sr << 1;
                        r_mosi  <= r_tx_sr[WIDTH-2];
                        if (r_bit_cnt != BIT_W'(WIDTH - 1)) begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (w_next_state == GAP) begin
                        r_cs     <= 1'b1;
                        r_mosi   <= 1'b0;
                        r_done   <= 1'b1;
                        r_rx_out <= r_rx_sr;
                    end
                end
                GAP: begin
                    if (w_next_state == IDLE) begin
                        r_busy <= 1'b0;
                    end
                end
                default: begin
                    r_cs <= r_cs;
                end
            endcase
        end
    end

    assign bus.CS             = r_cs;
    assign bus.CLK            = w_clk;
    assign bus.MOSI           = r_mosi;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.data_from_miso = r_rx_out;

endmodule
